// File: rtl/div_unit.sv
// Iterative restoring divider for RISC-V M: DIV, DIVU, REM and REMU on WIDTH-bit operands.
// Latency: 33 cycles from an accepted start to the done pulse; divide-by-zero and signed overflow take 1 cycle.
// Backpressure: busy holds the EX stage; start is sampled only in IDLE and ignored while busy.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic [1:0]       div_op,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   localparam int              CW    = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST  = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   logic [CW-1:0]    cnt;
   // dvd starts as |dividend| and collects quotient bits from the right as it shifts out
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic [WIDTH-1:0] rem_q;
   logic             qneg_q;
   logic             rneg_q;
   logic             rem_sel_q;

   logic             signed_op;
   logic             ovf;
   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   sub;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] res_nx;

   // Operand conditioning at start: magnitudes and the signed-overflow special case.
   // Negating MIN_V yields MIN_V, which read as unsigned is exactly 2^(WIDTH-1).
   always_comb begin
      signed_op = ~div_op[0];
      abs1      = (signed_op && op1[WIDTH-1]) ? (~op1 + ONE) : op1;
      abs2      = (signed_op && op2[WIDTH-1]) ? (~op2 + ONE) : op2;
      ovf       = signed_op && (op1 == MIN_V) && (op2 == '1);
   end

   // One restoring step: shift in next dividend bit, subtract divisor when it fits.
   always_comb begin
      rem_sh = {rem_q, dvd_q[WIDTH-1]};
      sub    = rem_sh - {1'b0, dvs_q};
      ge     = (rem_sh >= {1'b0, dvs_q});
      rem_nx = ge ? sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   end

   // Final sign correction and quotient/remainder selection.
   always_comb begin
      quo_fix = qneg_q ? (~dvd_q + ONE) : dvd_q;
      rem_fix = rneg_q ? (~rem_q + ONE) : rem_q;
      res_nx  = rem_sel_q ? rem_fix : quo_fix;
   end

   // Control FSM and datapath registers; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         rem_sel_q <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  rem_sel_q <= div_op[1];
                  cnt       <= '0;
                  dvs_q     <= abs2;
                  if (op2 == '0) begin
                     // Divide by zero: quotient all ones, remainder is the dividend
                     dvd_q  <= '1;
                     rem_q  <= op1;
                     qneg_q <= 1'b0;
                     rneg_q <= 1'b0;
                     state  <= FINISH;
                  end else if (ovf) begin
                     // MIN / -1: quotient wraps to MIN, remainder is zero
                     dvd_q  <= MIN_V;
                     rem_q  <= '0;
                     qneg_q <= 1'b0;
                     rneg_q <= 1'b0;
                     state  <= FINISH;
                  end else begin
                     dvd_q  <= abs1;
                     rem_q  <= '0;
                     qneg_q <= signed_op & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                     rneg_q <= signed_op & op1[WIDTH-1];
                     state  <= CALC;
                  end
               end
            end
            CALC: begin
               dvd_q <= {dvd_q[WIDTH-2:0], ge};
               rem_q <= rem_nx;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               result <= res_nx;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus multi-cycle sequences.
// Checks latency, busy/done timing, result hold, ignored starts and reset abort.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_div_unit;

   localparam logic [1:0] OP_DIV  = 2'd0;
   localparam logic [1:0] OP_DIVU = 2'd1;
   localparam logic [1:0] OP_REM  = 2'd2;
   localparam logic [1:0] OP_REMU = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] op1;
   logic [31:0] op2;
   logic [1:0]  div_op;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] held;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op1    (op1),
      .op2    (op2),
      .div_op (div_op),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge where done is seen.
   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int glitch_k);
      int   seen;
      logic bad;
      seen   = 99;
      bad    = 1'b0;
      start  = 1'b1;
      div_op = op;
      op1    = a;
      op2    = b;
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0 || result !== held) bad = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         if (glitch_k != 0 && k == glitch_k) begin
            start = 1'b1;
            op1   = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done === 1'b1) begin
            seen = k;
            break;
         end
         if (busy !== 1'b1 || result !== held) bad = 1'b1;
      end
      start = 1'b0;
      if (seen != 99 && busy !== 1'b0) bad = 1'b1;
      check({name, " latency"}, 32'(seen), 32'(lat));
      check({name, " busy/hold"}, 32'(bad), 32'd0);
      check({name, " result"}, result, exp);
      held = exp;
   endtask

   initial begin
      int   bad;
      vecs[0]  = '{OP_DIV,  32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 33};
      vecs[1]  = '{OP_REM,  32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 33};
      vecs[2]  = '{OP_REMU, 32'd100,       32'd7,        32'd2,        33};
      vecs[3]  = '{OP_DIVU, 32'h12345678,  32'd0,        32'hFFFFFFFF, 1};
      vecs[4]  = '{OP_REM,  32'h12345678,  32'd0,        32'h12345678, 1};
      vecs[5]  = '{OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1};
      vecs[6]  = '{OP_REM,  32'h80000000,  32'hFFFFFFFF, 32'd0,        1};
      vecs[7]  = '{OP_DIVU, 32'hFFFFFFFF,  32'd1,        32'hFFFFFFFF, 33};
      vecs[8]  = '{OP_DIV,  32'h80000000,  32'd2,        32'hC0000000, 33};
      vecs[9]  = '{OP_DIVU, 32'h80000000,  32'hFFFFFFFF, 32'd0,        33};
      vecs[10] = '{OP_REMU, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 33};
      vecs[11] = '{OP_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33};
      vecs[12] = '{OP_REM,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33};
      vecs[13] = '{OP_DIV,  32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33};
      vecs[14] = '{OP_REM,  32'd7,         32'hFFFFFFFE, 32'd1,        33};
      vecs[15] = '{OP_REMU, 32'd5,         32'd10,       32'd5,        33};
      vecs[16] = '{OP_DIV,  32'd0,         32'd0,        32'hFFFFFFFF, 1};
      vecs[17] = '{OP_REMU, 32'd0,         32'd0,        32'd0,        1};
      vecs[18] = '{OP_DIV,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'd1,        33};
      vecs[19] = '{OP_REM,  32'h80000000,  32'd3,        32'hFFFFFFFE, 33};
      vecs[20] = '{OP_DIV,  32'h80000000,  32'd3,        32'hD5555556, 33};

      rst    = 1'b1;
      start  = 1'b0;
      op1    = '0;
      op2    = '0;
      div_op = '0;
      held   = '0;

      // Reset state
      @(negedge clk);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Table of directed operations, each launched in the done cycle of the previous one
      for (int i = 0; i < NV; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
      end

      // Done is a single-cycle pulse and result holds afterwards
      @(negedge clk);
      check("done pulse width", 32'(done), 32'd0);
      check("result held idle", result, held);

      // Second start while busy is ignored
      do_op("ignored start", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33, 5);

      // Back-to-back: second start in the done cycle
      do_op("b2b first", OP_DIVU, 32'd84, 32'd4, 32'd21, 33, 0);
      do_op("b2b second", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
      @(negedge clk);

      // Reset in the middle of CALC aborts the operation
      start  = 1'b1;
      div_op = OP_DIVU;
      op1    = 32'd1000;
      op2    = 32'd10;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      #1;
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      check("abort result", result, 32'd0);
      held = '0;
      @(negedge clk);
      check("start during rst", 32'(busy), 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      bad   = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      check("no done after abort", 32'(bad), 32'd0);

      // Recovery after abort
      do_op("after reset", OP_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
